// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris input stage and game core:
// DAS state encoding and board geometry.
package tetris_pkg;

  typedef enum logic [1:0] {
    DAS_IDLE,
    DAS_DELAY,
    DAS_REPEAT
  } das_state_t;

  localparam int BOARD_W = 8;
  localparam int BOARD_H = 16;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a counting debouncer. The stable level
// flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // this disagreement cycle would make the count reach the threshold
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Button conditioning for the tetris core: debounced buttons become one-cycle
// move/rotate pulses (with auto-repeat on left/right) plus the gravity tick.
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DAS_DELAY       = 32,
  parameter int DAS_PERIOD      = 8,
  parameter int GRAVITY_PERIOD  = 1000,
  parameter int SOFT_PERIOD     = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  input  logic btn_down,
  input  logic game_en,
  output logic left_pulse,
  output logic right_pulse,
  output logic rotate_pulse,
  output logic fall_tick
);

  import tetris_pkg::das_state_t;
  import tetris_pkg::DAS_IDLE;
  import tetris_pkg::DAS_REPEAT;

  localparam int DAS_MAX = (DAS_DELAY > DAS_PERIOD) ? DAS_DELAY : DAS_PERIOD;
  localparam int DW      = $clog2(DAS_MAX) + 1;
  localparam int GW      = $clog2(GRAVITY_PERIOD) + 1;
  localparam logic [DW-1:0] DELAY_LAST  = DW'(DAS_DELAY - 1);
  localparam logic [DW-1:0] PERIOD_LAST = DW'(DAS_PERIOD - 1);
  localparam logic [GW-1:0] GRAV_LAST   = GW'(GRAVITY_PERIOD - 1);
  localparam logic [GW-1:0] SOFT_LAST   = GW'(SOFT_PERIOD - 1);

  logic stable_left;
  logic stable_right;
  logic stable_rotate;
  logic stable_down;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clock(clock), .reset(reset), .raw(btn_left), .stable(stable_left)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clock(clock), .reset(reset), .raw(btn_right), .stable(stable_right)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rotate (
    .clock(clock), .reset(reset), .raw(btn_rotate), .stable(stable_rotate)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clock(clock), .reset(reset), .raw(btn_down), .stable(stable_down)
  );

  // Index 0 = left, 1 = right. Left has priority, so it blocks right.
  logic [1:0] held;
  logic [1:0] blocked;
  assign held    = {stable_right, stable_left};
  assign blocked = {stable_left, 1'b0};

  das_state_t    das_state      [2];
  das_state_t    das_state_next [2];
  logic [DW-1:0] das_cnt        [2];
  logic [DW-1:0] das_cnt_next   [2];
  logic [1:0]    move;

  always_comb begin
    move = '0;
    for (int d = 0; d < 2; d++) begin
      das_state_next[d] = das_state[d];
      das_cnt_next[d]   = das_cnt[d];
      if (!held[d] || blocked[d]) begin
        das_state_next[d] = DAS_IDLE;
        das_cnt_next[d]   = '0;
      end else begin
        case (das_state[d])
          DAS_IDLE: begin
            das_state_next[d] = tetris_pkg::DAS_DELAY;
            das_cnt_next[d]   = '0;
            move[d]           = 1'b1;
          end
          tetris_pkg::DAS_DELAY: begin
            if (das_cnt[d] == DELAY_LAST) begin
              das_state_next[d] = DAS_REPEAT;
              das_cnt_next[d]   = '0;
              move[d]           = 1'b1;
            end else begin
              das_cnt_next[d] = das_cnt[d] + 1'b1;
            end
          end
          DAS_REPEAT: begin
            if (das_cnt[d] == PERIOD_LAST) begin
              das_cnt_next[d] = '0;
              move[d]         = 1'b1;
            end else begin
              das_cnt_next[d] = das_cnt[d] + 1'b1;
            end
          end
          default: begin
            das_state_next[d] = DAS_IDLE;
            das_cnt_next[d]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        das_state[d] <= DAS_IDLE;
        das_cnt[d]   <= '0;
      end else begin
        das_state[d] <= das_state_next[d];
        das_cnt[d]   <= das_cnt_next[d];
      end
    end
  end

  logic          rotate_prev;
  logic [GW-1:0] grav_cnt;
  logic [GW-1:0] grav_last;

  // >= rather than == so a limit that shrinks under the count still fires
  assign grav_last = stable_down ? SOFT_LAST : GRAV_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      left_pulse   <= 1'b0;
      right_pulse  <= 1'b0;
      rotate_pulse <= 1'b0;
      fall_tick    <= 1'b0;
      rotate_prev  <= 1'b0;
      grav_cnt     <= '0;
    end else begin
      left_pulse   <= move[0] & game_en;
      right_pulse  <= move[1] & game_en;
      rotate_pulse <= stable_rotate & ~rotate_prev & game_en;
      rotate_prev  <= stable_rotate;
      fall_tick    <= 1'b0;
      if (game_en) begin
        if (grav_cnt >= grav_last) begin
          fall_tick <= 1'b1;
          grav_cnt  <= '0;
        end else begin
          grav_cnt <= grav_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: each scenario pushes the cycle
// numbers at which every output must pulse; a negedge monitor pops them.
module tb_tetris_input_ctrl;

  logic clock;
  logic reset;
  logic btn_left;
  logic btn_right;
  logic btn_rotate;
  logic btn_down;
  logic game_en;
  logic left_pulse;
  logic right_pulse;
  logic rotate_pulse;
  logic fall_tick;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DAS_DELAY(10),
    .DAS_PERIOD(3),
    .GRAVITY_PERIOD(20),
    .SOFT_PERIOD(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_rotate(btn_rotate),
    .btn_down(btn_down),
    .game_en(game_en),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .rotate_pulse(rotate_pulse),
    .fall_tick(fall_tick)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] r;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q_left[$];
  logic [31:0] exp_q_right[$];
  logic [31:0] exp_q_rotate[$];
  logic [31:0] exp_q_fall[$];

  function automatic int q_size(input int ch);
    case (ch)
      0:       return exp_q_left.size();
      1:       return exp_q_right.size();
      2:       return exp_q_rotate.size();
      default: return exp_q_fall.size();
    endcase
  endfunction

  function automatic logic [31:0] q_front(input int ch);
    case (ch)
      0:       return exp_q_left[0];
      1:       return exp_q_right[0];
      2:       return exp_q_rotate[0];
      default: return exp_q_fall[0];
    endcase
  endfunction

  task automatic q_pop(input int ch);
    case (ch)
      0:       void'(exp_q_left.pop_front());
      1:       void'(exp_q_right.pop_front());
      2:       void'(exp_q_rotate.pop_front());
      default: void'(exp_q_fall.pop_front());
    endcase
  endtask

  task automatic push_exp(input int ch, input logic [31:0] t);
    case (ch)
      0:       exp_q_left.push_back(t);
      1:       exp_q_right.push_back(t);
      2:       exp_q_rotate.push_back(t);
      default: exp_q_fall.push_back(t);
    endcase
  endtask

  task automatic mon(input int ch, input string name, input logic v);
    while (q_size(ch) > 0 && q_front(ch) < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s missed: got no pulse, expected one at cycle %0d (now %0d)",
               name, q_front(ch), cyc);
      q_pop(ch);
    end
    if (v) begin
      checks++;
      if (q_size(ch) == 0) begin
        errors++;
        $display("FAIL %s unexpected: got pulse at cycle %0d, expected none", name, cyc);
      end else if (q_front(ch) != cyc) begin
        errors++;
        $display("FAIL %s timing: got pulse at cycle %0d, expected at cycle %0d",
                 name, cyc, q_front(ch));
      end else begin
        q_pop(ch);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, "left_pulse", left_pulse);
    mon(1, "right_pulse", right_pulse);
    mon(2, "rotate_pulse", rotate_pulse);
    mon(3, "fall_tick", fall_tick);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input logic [31:0] t);
    while (cyc < t) step();
  endtask

  // Two reset edges; outputs are checked after the first. r marks release.
  task automatic begin_scn();
    reset = 1'b1;
    step();
    chk("reset left_pulse", left_pulse, 1'b0);
    chk("reset right_pulse", right_pulse, 1'b0);
    chk("reset rotate_pulse", rotate_pulse, 1'b0);
    chk("reset fall_tick", fall_tick, 1'b0);
    step();
    reset = 1'b0;
    r = cyc;
  endtask

  task automatic push_ticks(input logic [31:0] base, input int len);
    for (int k = 20; k <= len; k += 20) push_exp(3, base + k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_rotate = 1'b0;
    btn_down   = 1'b0;
    game_en    = 1'b1;
    step();

    // idle game: gravity only
    begin_scn();
    push_ticks(r, 60);
    wait_until(r + 60);

    // bouncing left never settles
    begin_scn();
    push_ticks(r, 40);
    for (int i = 0; i < 12; i++) begin
      btn_left = (i % 2 == 0);
      step();
    end
    btn_left = 1'b0;
    wait_until(r + 40);

    // left held 40 cycles: initial, delay, repeats
    begin_scn();
    push_ticks(r, 70);
    btn_left = 1'b1;
    push_exp(0, r + 7);
    push_exp(0, r + 17);
    for (int t = 20; t <= 44; t += 3) push_exp(0, r + t);
    wait_until(r + 40);
    btn_left = 1'b0;
    wait_until(r + 70);

    // left and right together; left released at 20
    begin_scn();
    push_ticks(r, 75);
    btn_left  = 1'b1;
    btn_right = 1'b1;
    push_exp(0, r + 7);
    push_exp(0, r + 17);
    push_exp(0, r + 20);
    push_exp(0, r + 23);
    push_exp(0, r + 26);
    push_exp(1, r + 27);
    for (int t = 37; t <= 64; t += 3) push_exp(1, r + t);
    wait_until(r + 20);
    btn_left = 1'b0;
    wait_until(r + 60);
    btn_right = 1'b0;
    wait_until(r + 75);

    // soft drop, release, then game_en low for 30 cycles
    begin_scn();
    btn_down = 1'b1;
    push_exp(3, r + 7);
    push_exp(3, r + 12);
    push_exp(3, r + 17);
    push_exp(3, r + 22);
    push_exp(3, r + 27);
    push_exp(3, r + 32);
    push_exp(3, r + 52);
    push_exp(3, r + 72);
    push_exp(3, r + 122);
    push_exp(3, r + 142);
    wait_until(r + 30);
    btn_down = 1'b0;
    wait_until(r + 75);
    game_en = 1'b0;
    step();
    btn_left = 1'b1;
    wait_until(r + 85);
    btn_left = 1'b0;
    wait_until(r + 105);
    game_en = 1'b1;
    wait_until(r + 145);

    // rotate held 50 cycles: one pulse
    begin_scn();
    push_ticks(r, 60);
    btn_rotate = 1'b1;
    push_exp(2, r + 7);
    wait_until(r + 50);
    btn_rotate = 1'b0;
    wait_until(r + 60);

    // rotate held through a reset: fresh pulse after release
    begin_scn();
    push_ticks(r, 20);
    btn_rotate = 1'b1;
    push_exp(2, r + 7);
    wait_until(r + 20);
    begin_scn();
    push_ticks(r, 60);
    push_exp(2, r + 7);
    wait_until(r + 50);
    btn_rotate = 1'b0;
    wait_until(r + 60);

    repeat (3) step();
    for (int ch = 0; ch < 4; ch++) begin
      while (q_size(ch) > 0) begin
        checks++;
        errors++;
        $display("FAIL leftover ch%0d: got no pulse, expected one at cycle %0d",
                 ch, q_front(ch));
        q_pop(ch);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
